// File: rtl/test_sequencer.sv
// Runs a table of CSR_TEST_PARAM words back-to-back through the test control block.
// Optional build macro SEQ_STOP_ON_FAIL_EN ends the sequence at the first failing test.
module test_sequencer #(
   parameter int unsigned NUM_TESTS = 8,
   parameter int unsigned IDX_W     = $clog2(NUM_TESTS),
   parameter int unsigned CNT_W     = $clog2(NUM_TESTS + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             tbl_wr_i,
   input  logic [IDX_W-1:0] tbl_addr_i,
   input  logic [31:0]      tbl_data_i,
   input  logic             seq_start_i,
   input  logic [CNT_W-1:0] seq_len_i,
   input  logic             seq_abort_i,
   output logic             seq_busy_o,
   output logic             seq_done_o,
   output logic             seq_aborted_o,
   output logic [IDX_W-1:0] cur_idx_o,
   output logic [CNT_W-1:0] fail_cnt_o,
   output logic             first_fail_vld_o,
   output logic [IDX_W-1:0] first_fail_idx_o,
   output logic             test_start_o,
   output logic [31:0]      test_param_o,
   input  logic             test_finished_i,
   input  logic             test_result_i
);

   typedef enum logic [2:0] {
      StIdle, StLoad, StStart, StArm, StWait, StNext, StDone
   } state_e;

   state_e           state_q, state_d;
   logic [31:0]      tbl_q [NUM_TESTS];
   logic [IDX_W-1:0] idx_q, idx_d, cur_idx_q, cur_idx_d, ffi_q, ffi_d;
   logic [CNT_W-1:0] len_q, len_d, fail_q, fail_d, len_sat;
   logic [31:0]      param_q, param_d;
   logic             busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
   logic             ffv_q, ffv_d, abort_pend_q, abort_pend_d;
   logic             last_entry, stop_now;

   // Table has no reset; contents are undefined until software writes them.
   always_ff @(posedge clk_i) begin
      if (tbl_wr_i && (state_q == StIdle) && (32'(tbl_addr_i) < NUM_TESTS)) begin
         tbl_q[tbl_addr_i] <= tbl_data_i;
      end
   end

   assign len_sat    = (32'(seq_len_i) > NUM_TESTS) ? CNT_W'(NUM_TESTS) : seq_len_i;
   assign last_entry = ((CNT_W'(idx_q) + CNT_W'(1)) == len_q);
`ifdef SEQ_STOP_ON_FAIL_EN
   assign stop_now   = last_entry || abort_pend_q || test_result_i;
`else
   assign stop_now   = last_entry || abort_pend_q;
`endif

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cur_idx_d    = cur_idx_q;
      ffi_d        = ffi_q;
      len_d        = len_q;
      fail_d       = fail_q;
      param_d      = param_q;
      busy_d       = busy_q;
      done_d       = done_q;
      aborted_d    = aborted_q;
      ffv_d        = ffv_q;
      abort_pend_d = abort_pend_q;
      unique case (state_q)
         StIdle: begin
            if (seq_start_i) begin
               len_d        = len_sat;
               idx_d        = '0;
               fail_d       = '0;
               ffv_d        = 1'b0;
               ffi_d        = '0;
               done_d       = 1'b0;
               aborted_d    = 1'b0;
               abort_pend_d = 1'b0;
               busy_d       = 1'b1;
               state_d      = (len_sat == '0) ? StDone : StLoad;
            end
         end
         StLoad: begin
            param_d   = tbl_q[idx_q];
            cur_idx_d = idx_q;
            state_d   = StStart;
         end
         StStart: state_d = StArm;
         // finished flag still reflects the previous test in this cycle
         StArm:   state_d = StWait;
         StWait: begin
            if (test_finished_i) state_d = StNext;
         end
         StNext: begin
            if (test_result_i) begin
               fail_d = fail_q + CNT_W'(1);
               if (!ffv_q) begin
                  ffv_d = 1'b1;
                  ffi_d = idx_q;
               end
            end
            if (stop_now) begin
               state_d = StDone;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = StLoad;
            end
         end
         StDone: begin
            busy_d    = 1'b0;
            done_d    = 1'b1;
            aborted_d = abort_pend_q;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (seq_abort_i && (state_q inside {StLoad, StStart, StArm, StWait})) begin
         abort_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         cur_idx_q    <= '0;
         ffi_q        <= '0;
         len_q        <= '0;
         fail_q       <= '0;
         param_q      <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
         ffv_q        <= 1'b0;
         abort_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cur_idx_q    <= cur_idx_d;
         ffi_q        <= ffi_d;
         len_q        <= len_d;
         fail_q       <= fail_d;
         param_q      <= param_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         aborted_q    <= aborted_d;
         ffv_q        <= ffv_d;
         abort_pend_q <= abort_pend_d;
      end
   end

   assign seq_busy_o       = busy_q;
   assign seq_done_o       = done_q;
   assign seq_aborted_o    = aborted_q;
   assign cur_idx_o        = cur_idx_q;
   assign fail_cnt_o       = fail_q;
   assign first_fail_vld_o = ffv_q;
   assign first_fail_idx_o = ffi_q;
   assign test_start_o     = (state_q == StStart);
   assign test_param_o     = param_q;

endmodule
